// File: rtl/router_pkt_fifo.sv
// Packet-aware per-port FIFO: stores a header flag with every word and tracks the
// remaining words of the packet being read so downstream logic can find packet ends.
module router_pkt_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned LEN_LSB   = 2,
  parameter int unsigned LEN_W     = 6,
  parameter int unsigned AF_THRESH = DEPTH - 2
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       soft_reset,
  input  logic                       write_enb,
  input  logic                       sop_in,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       read_enb,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_valid,
  output logic                       sop_out,
  output logic                       full,
  output logic                       almost_full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [LEN_W:0]             pkt_rem,
  output logic                       pkt_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic              full_q, full_d, almost_full_q, almost_full_d, empty_q, empty_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              sop_out_q, sop_out_d, data_valid_q, data_valid_d;
  logic [LEN_W:0]    pkt_rem_q, pkt_rem_d;
  logic              pkt_err_q, pkt_err_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W:0]   rd_word;

  always_comb begin
    wr_acc        = write_enb & ~full_q & ~soft_reset;
    rd_acc        = read_enb & ~empty_q & ~soft_reset;
    rd_word       = mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    data_out_d    = data_out_q;
    sop_out_d     = sop_out_q;
    data_valid_d  = rd_acc;
    pkt_rem_d     = pkt_rem_q;
    pkt_err_d     = pkt_err_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (rd_acc) begin
      data_out_d = rd_word[DATA_W-1:0];
      sop_out_d  = rd_word[DATA_W];
      if (rd_word[DATA_W]) begin
        // Reload covers payload plus the trailing parity word.
        if (pkt_rem_q != '0) pkt_err_d = 1'b1;
        pkt_rem_d = {1'b0, rd_word[LEN_LSB+LEN_W-1:LEN_LSB]} + 1'b1;
      end else if (pkt_rem_q != '0) begin
        pkt_rem_d = pkt_rem_q - 1'b1;
      end
    end

    if (soft_reset) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      sop_out_d    = 1'b0;
      data_valid_d = 1'b0;
      pkt_rem_d    = '0;
      pkt_err_d    = 1'b0;
    end

    full_d        = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_d       = (wr_ptr_d == rd_ptr_d);
    almost_full_d = (level_d >= LW'(AF_THRESH));
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      empty_q       <= 1'b1;
      data_out_q    <= '0;
      sop_out_q     <= 1'b0;
      data_valid_q  <= 1'b0;
      pkt_rem_q     <= '0;
      pkt_err_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      empty_q       <= empty_d;
      data_out_q    <= data_out_d;
      sop_out_q     <= sop_out_d;
      data_valid_q  <= data_valid_d;
      pkt_rem_q     <= pkt_rem_d;
      pkt_err_q     <= pkt_err_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (resetn && wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= {sop_in, data_in};
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign sop_out     = sop_out_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign empty       = empty_q;
  assign level       = level_q;
  assign pkt_rem     = pkt_rem_q;
  assign pkt_err     = pkt_err_q;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Bench for router_pkt_fifo: directed scenarios plus random traffic, all checked
// against a queue-based model of the FIFO and packet-length tracking.
module tb_router_pkt_fifo;

  logic       clock = 1'b0;
  logic       resetn, soft_reset, write_enb, sop_in, read_enb;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_valid, sop_out, full, almost_full, empty, pkt_err;
  logic [4:0] level;
  logic [6:0] pkt_rem;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [8:0] q[$];
  int         m_rem;
  bit         m_err, m_sop, m_valid;
  logic [7:0] m_data;

  router_pkt_fifo dut (
    .clock       (clock),
    .resetn      (resetn),
    .soft_reset  (soft_reset),
    .write_enb   (write_enb),
    .sop_in      (sop_in),
    .data_in     (data_in),
    .read_enb    (read_enb),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .sop_out     (sop_out),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .level       (level),
    .pkt_rem     (pkt_rem),
    .pkt_err     (pkt_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rn, input bit sr, input bit we, input bit sop,
                            input logic [7:0] d, input bit re);
    bit racc, wacc;
    logic [8:0] w;
    if (!rn) begin
      q.delete(); m_rem = 0; m_err = 0; m_sop = 0; m_valid = 0; m_data = 8'h00;
    end else if (sr) begin
      q.delete(); m_rem = 0; m_err = 0; m_sop = 0; m_valid = 0;
    end else begin
      racc = re && (q.size() > 0);
      wacc = we && (q.size() < 16);
      m_valid = racc;
      if (racc) begin
        w = q.pop_front();
        m_data = w[7:0];
        m_sop  = w[8];
        if (w[8]) begin
          if (m_rem != 0) m_err = 1;
          m_rem = int'(w[7:2]) + 1;
        end else if (m_rem > 0) begin
          m_rem--;
        end
      end
      if (wacc) q.push_back({sop, d});
    end
  endtask

  task automatic check_all();
    chk("data_out",    32'(data_out),    32'(m_data));
    chk("data_valid",  32'(data_valid),  32'(m_valid));
    chk("sop_out",     32'(sop_out),     32'(m_sop));
    chk("level",       32'(level),       32'(q.size()));
    chk("full",        32'(full),        32'(q.size() == 16));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= 14));
    chk("empty",       32'(empty),       32'(q.size() == 0));
    chk("pkt_rem",     32'(pkt_rem),     32'(m_rem));
    chk("pkt_err",     32'(pkt_err),     32'(m_err));
  endtask

  task automatic cycle(input bit rn, input bit sr, input bit we, input bit sop,
                       input logic [7:0] d, input bit re);
    @(negedge clock);
    resetn = rn; soft_reset = sr; write_enb = we; sop_in = sop; data_in = d; read_enb = re;
    @(posedge clock);
    model_step(rn, sr, we, sop, d, re);
    #1;
    check_all();
  endtask

  task automatic wr(input bit sop, input logic [7:0] d);
    cycle(1, 0, 1, sop, d, 0);
  endtask

  task automatic rd();
    cycle(1, 0, 0, 0, 8'h00, 1);
  endtask

  initial begin
    logic [7:0] pkt [5];
    logic [7:0] held;
    pkt[0] = 8'h0C; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3; pkt[4] = 8'h5F;

    // Reset
    cycle(0, 0, 0, 0, 8'h00, 0);
    cycle(0, 0, 1, 1, 8'hFF, 1);
    chk("reset_empty", 32'(empty), 32'd1);

    // Single packet: header len=3, three payload words, parity
    for (int i = 0; i < 5; i++) wr(i == 0, pkt[i]);
    for (int i = 0; i < 5; i++) begin
      rd();
      chk("pkt_data", 32'(data_out), 32'(pkt[i]));
      chk("pkt_rem_seq", 32'(pkt_rem), 32'(4 - i));
    end
    rd();
    chk("pkt_drain_valid", 32'(data_valid), 32'd0);

    // Fill to full, overflow write dropped, drain in order
    for (int i = 0; i < 17; i++) wr(0, 8'(8'h30 + i));
    chk("full_after_16", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk("fill_order", 32'(data_out), 32'(8'h30 + i));
    end

    // Simultaneous read+write at full and at empty
    for (int i = 0; i < 16; i++) wr(0, 8'(i));
    cycle(1, 0, 1, 0, 8'hEE, 1);
    chk("full_rw_level", 32'(level), 32'd15);
    for (int i = 0; i < 15; i++) rd();
    cycle(1, 0, 1, 0, 8'hDD, 1);
    chk("empty_rw_level", 32'(level), 32'd1);
    chk("empty_rw_valid", 32'(data_valid), 32'd0);
    rd();

    // Streaming across pointer wrap
    for (int i = 0; i < 41; i++) begin
      cycle(1, 0, i < 40, 0, 8'(8'h80 + i), i > 0);
      chk("stream_level_le1", 32'(level <= 1), 32'd1);
      if (i > 0) chk("stream_data", 32'(data_out), 32'(8'h80 + i - 1));
    end

    // Header while packet still open sets sticky pkt_err
    wr(1, 8'h08); wr(0, 8'h11); wr(1, 8'h08);
    rd(); rd(); rd();
    chk("err_set", 32'(pkt_err), 32'd1);
    chk("err_reload", 32'(pkt_rem), 32'd3);
    cycle(1, 0, 0, 0, 8'h00, 0);
    chk("err_sticky", 32'(pkt_err), 32'd1);
    cycle(1, 1, 0, 0, 8'h00, 0);
    chk("err_cleared", 32'(pkt_err), 32'd0);

    // soft_reset mid-packet with level 6; same-cycle write not stored
    wr(1, 8'h1C);
    for (int i = 0; i < 6; i++) wr(0, 8'(8'h60 + i));
    rd();
    chk("pre_sr_level", 32'(level), 32'd6);
    held = data_out;
    cycle(1, 1, 1, 0, 8'h77, 1);
    chk("sr_level", 32'(level), 32'd0);
    chk("sr_data_hold", 32'(data_out), 32'(held));
    cycle(1, 0, 0, 0, 8'h00, 1);
    chk("sr_write_dropped", 32'(empty), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit sop;
      logic [7:0] d;
      sop = ($urandom_range(0, 4) == 0);
      d   = 8'($urandom);
      if (sop) d[7:2] = 6'($urandom_range(0, 5));
      cycle($urandom_range(0, 199) != 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 2) != 0, sop, d, $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
